// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state type and the canonical NOP encoding.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        VALID
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: single-outstanding req/gnt + rvalid read of instruction
// memory, holding the fetched instruction for decode under a valid/ready handshake.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            fetch_err_o
);

    fetch_state_e state, state_next;
    logic         misaligned;
    logic         granted;

    assign misaligned  = (pc_i[1:0] != 2'b00);
    assign imem_req_o  = (state == REQ) && !misaligned;
    assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
    assign granted     = imem_req_o && imem_gnt_i;
    assign pc_en_o     = ((state == VALID) && instr_ready_i) || flush_i;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                // A redirect beats both a grant and a misalignment fault.
                if (flush_i)
                    state_next = granted ? DRAIN : REQ;
                else if (misaligned)
                    state_next = VALID;
                else if (granted)
                    state_next = WAIT;
            end
            WAIT: begin
                if (flush_i)
                    state_next = imem_rvalid_i ? REQ : DRAIN;
                else if (imem_rvalid_i)
                    state_next = VALID;
            end
            DRAIN: begin
                if (imem_rvalid_i)
                    state_next = REQ;
            end
            VALID: begin
                if (flush_i || instr_ready_i)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            instr_valid_o <= 1'b0;
            instr_o       <= ILEN'(NOP_INSTR);
            instr_pc_o    <= '0;
            fetch_err_o   <= 1'b0;
        end else begin
            state         <= state_next;
            instr_valid_o <= (state_next == VALID);
            unique case (state)
                REQ: begin
                    if (!flush_i) begin
                        if (misaligned) begin
                            instr_o     <= ILEN'(NOP_INSTR);
                            fetch_err_o <= 1'b1;
                            instr_pc_o  <= pc_i;
                        end else if (granted) begin
                            instr_pc_o  <= pc_i;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i && !flush_i) begin
                        instr_o     <= imem_err_i ? ILEN'(NOP_INSTR) : imem_rdata_i;
                        fetch_err_o <= imem_err_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a transaction-level delivery model checked every cycle.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_i = '0;
    logic        pc_en_o;
    logic        flush_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fetch_err_o;
    logic [31:0] redirect_pc = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] pc; logic drop; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } dlv_t;
    out_t outq[$];
    dlv_t expq[$];
    out_t o_tmp;
    dlv_t d_tmp;

    ifetch_unit #(.XLEN(32), .ILEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic err);
        check({tag, "_valid"}, instr_valid_o, 1);
        check({tag, "_instr"}, instr_o, instr);
        check({tag, "_pc"}, instr_pc_o, pc);
        check({tag, "_err"}, fetch_err_o, err);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_req"}, imem_req_o, 0);
        check({tag, "_valid"}, instr_valid_o, 0);
        check({tag, "_instr"}, instr_o, NOP);
        check({tag, "_pc"}, instr_pc_o, 0);
        check({tag, "_err"}, fetch_err_o, 0);
        check({tag, "_pc_en"}, pc_en_o, 0);
    endtask

    // PC register with load enable: +4 on consume, redirect target on flush.
    task automatic tick();
        logic en;
        @(negedge clk);
        #1;
        en = pc_en_o;
        @(posedge clk);
        #1;
        if (en) pc_i = flush_i ? redirect_pc : pc_i + 32'd4;
    endtask

    // Starts in REQ with an aligned pc; zero-wait memory, decode ready immediately.
    task automatic fetch_fast(input string tag, input logic [31:0] data, input logic [31:0] pc_exp);
        imem_gnt_i = 1'b1;
        #1;
        check({tag, "_addr"}, imem_addr_o, pc_exp);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = data;
        tick();
        imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        chk_instr(tag, data, pc_exp, 1'b0);
        tick();
        instr_ready_i = 1'b0;
    endtask

    // Model: outstanding fetches and pending deliveries, updated from bus/handshake events.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                outq.delete();
                expq.delete();
                continue;
            end
            check("m_pc_en", pc_en_o, (instr_valid_o && instr_ready_i) || flush_i);
            if (imem_req_o) begin
                check("m_req_addr", imem_addr_o, {pc_i[31:2], 2'b00});
                check("m_req_aligned", pc_i[1:0], 0);
                check("m_one_outstanding", outq.size(), 0);
            end
            if (instr_valid_o) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL m_valid: actual instr_valid_o=1 required 0 (no delivery pending)");
                end else begin
                    check("m_instr", instr_o, expq[0].instr);
                    check("m_instr_pc", instr_pc_o, expq[0].pc);
                    check("m_err", fetch_err_o, expq[0].err);
                    if (flush_i || instr_ready_i) void'(expq.pop_front());
                end
            end
            if (imem_rvalid_i && outq.size() > 0) begin
                o_tmp = outq.pop_front();
                if (!o_tmp.drop && !flush_i) begin
                    d_tmp = '{pc: o_tmp.pc, instr: (imem_err_i ? NOP : imem_rdata_i), err: imem_err_i};
                    expq.push_back(d_tmp);
                end
            end
            if (imem_req_o && imem_gnt_i) outq.push_back('{pc: pc_i, drop: flush_i});
            if (flush_i) foreach (outq[i]) outq[i].drop = 1'b1;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        reset = 1'b0;

        // 1: zero-wait fetch of 0x0 then 0x4
        #1;
        check("t1_idle_req", imem_req_o, 0);
        tick();
        imem_gnt_i = 1'b1;
        #1;
        check("t1_req", imem_req_o, 1);
        check("t1_addr", imem_addr_o, 32'h0);
        check("t1_pc_en_req", pc_en_o, 0);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0010_0093;
        #1;
        check("t1_wait_valid", instr_valid_o, 0);
        tick();
        imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        chk_instr("t1_d0", 32'h0010_0093, 32'h0, 1'b0);
        check("t1_pc_en_accept", pc_en_o, 1);
        tick();
        instr_ready_i = 1'b0;
        #1;
        check("t1_next_req", imem_req_o, 1);
        fetch_fast("t1_d1", 32'h0020_0113, 32'h4);

        // 2: gnt after 3 cycles, rvalid on the 4th cycle after gnt
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_req_held", imem_req_o, 1);
            check("t2_addr_stable", imem_addr_o, 32'h8);
            check("t2_pc_en", pc_en_o, 0);
            tick();
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_wait_valid", instr_valid_o, 0);
            check("t2_wait_req", imem_req_o, 0);
            check("t2_wait_pc_en", pc_en_o, 0);
            tick();
        end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0030_8193;
        tick();
        imem_rvalid_i = 1'b0;

        // 3: decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_instr("t3_hold", 32'h0030_8193, 32'h8, 1'b0);
            check("t3_no_req", imem_req_o, 0);
            check("t3_pc_en", pc_en_o, 0);
            tick();
        end
        instr_ready_i = 1'b1;
        #1;
        check("t3_pc_en_accept", pc_en_o, 1);
        tick();
        instr_ready_i = 1'b0;

        // 4: flush in WAIT -> DRAIN drops stale data, refetch at 0x100
        imem_gnt_i = 1'b1;
        #1;
        check("t4_addr_c", imem_addr_o, 32'hC);
        tick();
        imem_gnt_i = 1'b0; flush_i = 1'b1; redirect_pc = 32'h100;
        #1;
        check("t4_pc_en_flush", pc_en_o, 1);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_drain_req", imem_req_o, 0);
            tick();
        end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("t4_drain_valid", instr_valid_o, 0);
        tick();
        imem_rvalid_i = 1'b0;
        fetch_fast("t4_d", 32'h0040_0213, 32'h100);

        // 4b: flush with gnt -> DRAIN; flush with rvalid in WAIT -> drop, REQ
        imem_gnt_i = 1'b1; flush_i = 1'b1; redirect_pc = 32'h200;
        #1;
        check("t4b_addr", imem_addr_o, 32'h104);
        tick();
        imem_gnt_i = 1'b0; flush_i = 1'b0;
        #1;
        check("t4b_drain_req", imem_req_o, 0);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAAD_F00D;
        tick();
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        #1;
        check("t4b_addr_200", imem_addr_o, 32'h200);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0060_0313;
        flush_i = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_rvalid_i = 1'b0; flush_i = 1'b0;
        #1;
        check("t4b_drop_valid", instr_valid_o, 0);
        check("t4b_req_300", imem_req_o, 1);
        check("t4b_addr_300", imem_addr_o, 32'h300);

        // 5: misaligned pc faults without a request; bus error delivers NOP
        flush_i = 1'b1; redirect_pc = 32'h102;
        expq.push_back('{pc: 32'h102, instr: NOP, err: 1'b1});
        tick();
        flush_i = 1'b0;
        #1;
        check("t5_no_req", imem_req_o, 0);
        tick();
        instr_ready_i = 1'b1;
        expq.push_back('{pc: 32'h106, instr: NOP, err: 1'b1});
        #1;
        chk_instr("t5_mis", NOP, 32'h102, 1'b1);
        tick();
        instr_ready_i = 1'b0;
        #1;
        check("t5_no_req_106", imem_req_o, 0);
        tick();
        instr_ready_i = 1'b1; flush_i = 1'b1; redirect_pc = 32'h400;
        #1;
        chk_instr("t5_mis2", NOP, 32'h106, 1'b1);
        tick();
        instr_ready_i = 1'b0; flush_i = 1'b0;
        #1;
        check("t5_flush_wins_valid", instr_valid_o, 0);
        imem_gnt_i = 1'b1;
        check("t5_addr_400", imem_addr_o, 32'h400);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_err_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        tick();
        imem_rvalid_i = 1'b0; imem_err_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        chk_instr("t5_buserr", NOP, 32'h400, 1'b1);
        tick();
        instr_ready_i = 1'b0;

        // 6: async reset mid-WAIT, late rvalid ignored, restart via IDLE
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("t6_rst");
        tick();
        reset = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBADB_AD00;
        #1;
        check("t6_idle_req", imem_req_o, 0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t6_valid_after_stale", instr_valid_o, 0);
        fetch_fast("t6_d", 32'h0050_0293, 32'h404);

        tick();
        check("model_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
